// File: rtl/reg_scoreboard.sv
// Register scoreboard: pending bit per GPR, set on issue, cleared on writeback; issue_ready is combinational, busy_vec is registered.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release RAW/WAW hazards immediately.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rs,
  input  logic [4:0]       issue_rt,
  input  logic             issue_rs_used,
  input  logic             issue_rt_used,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_count
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_next;
  logic            raw_a;
  logic            raw_b;
  logic            waw;
  logic            hazard;
  logic            fire;

  always_comb begin
    wb_mask = '0;
    if (wb_valid && wb_rd != 5'd0) wb_mask[wb_rd] = 1'b1;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The register file forwards the write data, so a committing register is already safe to read.
  assign pend = busy & ~wb_mask;
`else
  assign pend = busy;
`endif

  assign raw_a  = issue_rs_used && issue_rs != 5'd0 && pend[issue_rs];
  assign raw_b  = issue_rt_used && issue_rt != 5'd0 && pend[issue_rt];
  assign waw    = issue_wr && issue_rd != 5'd0 && pend[issue_rd];
  assign hazard = raw_a | raw_b | waw;

  assign issue_ready = rst || (!flush && !hazard);
  assign fire        = issue_valid && issue_ready && !rst && !flush;

  always_comb begin
    set_mask = '0;
    if (fire && issue_wr && issue_rd != 5'd0) set_mask[issue_rd] = 1'b1;
  end

  // Set is applied after clear so a new producer supersedes a same-cycle writeback.
  always_comb begin
    busy_next    = (busy & ~wb_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      stall_count <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
      if (issue_valid && !issue_ready && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard; expected state is queued at drive time and compared after the edge.
module tb_reg_scoreboard;

  localparam int CNT_W = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [4:0]       issue_rs;
  logic [4:0]       issue_rt;
  logic             issue_rs_used;
  logic             issue_rt_used;
  logic             issue_wr;
  logic [4:0]       issue_rd;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] stall_count;

  reg_scoreboard #(.NREG(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
    .issue_wr(issue_wr), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, flush, v;
    logic [4:0]  rs, rt, rd, wbrd;
    logic        rsu, rtu, wr, wbv;
    logic        exp_rdy;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    string            name;
    logic [31:0]      busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  vec_t             tbl[$];
  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  function automatic vec_t mk(string n, int r, int fl, int v, int rs, int rsu, int rt, int rtu,
                              int wr, int rd, int wbv, int wbrd, int rdy, logic [31:0] busy);
    vec_t x;
    x.name = n; x.rst = (r != 0); x.flush = (fl != 0); x.v = (v != 0);
    x.rs = 5'(rs); x.rsu = (rsu != 0); x.rt = 5'(rt); x.rtu = (rtu != 0);
    x.wr = (wr != 0); x.rd = 5'(rd); x.wbv = (wbv != 0); x.wbrd = 5'(wbrd);
    x.exp_rdy = (rdy != 0); x.exp_busy = busy;
    return x;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    rst = x.rst; flush = x.flush; issue_valid = x.v;
    issue_rs = x.rs; issue_rs_used = x.rsu; issue_rt = x.rt; issue_rt_used = x.rtu;
    issue_wr = x.wr; issue_rd = x.rd; wb_valid = x.wbv; wb_rd = x.wbrd;
  endtask

  task automatic apply(vec_t x);
    exp_t e;
    @(negedge clk);
    drive(x);
    #1;
    chk({x.name, ".ready"}, 32'(issue_ready), 32'(x.exp_rdy));
    if (x.rst) cnt_model = '0;
    else if (!x.flush && x.v && !x.exp_rdy && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + CNT_W'(1);
    e.name = x.name; e.busy = x.exp_busy; e.cnt = cnt_model;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".busy"}, busy_vec, e.busy);
    chk({e.name, ".cnt"}, 32'(stall_count), 32'(e.cnt));
  endtask

  initial begin
    drive(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));

    //             name       rst fl v  rs rsu rt rtu wr rd wbv wbrd rdy  busy
    tbl.push_back(mk("rst0",   1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("rst1",   1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("iss5",   0, 0, 1, 3, 1,  4, 1,  1, 5, 0, 0,   1,   32'h20));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("raw5", 0, 0, 1, 5, 1,  0, 0,  0, 0, 0, 0,   0,   32'h20));
    tbl.push_back(mk("raw_wb", 0, 0, 1, 5, 1,  0, 0,  0, 0, 1, 5,   BYP, 32'h0));
    tbl.push_back(mk("raw_go", 0, 0, 1, 5, 1,  0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("r0_iss", 0, 0, 1, 0, 0,  0, 0,  1, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("r0_use", 0, 0, 1, 0, 1,  0, 1,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("iss7",   0, 0, 1, 0, 0,  0, 0,  1, 7, 0, 0,   1,   32'h80));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk("waw7", 0, 0, 1, 0, 0,  0, 0,  1, 7, 0, 0,   0,   32'h80));
    tbl.push_back(mk("waw_wb", 0, 0, 1, 0, 0,  0, 0,  1, 7, 1, 7,   BYP, (BYP != 0) ? 32'h80 : 32'h0));
    tbl.push_back(mk("wb7",    0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 7,   1,   32'h0));
    tbl.push_back(mk("iss9",   0, 0, 1, 0, 0,  0, 0,  1, 9, 0, 0,   1,   32'h200));
    tbl.push_back(mk("unused9",0, 0, 1, 9, 0,  9, 0,  0, 0, 0, 0,   1,   32'h200));
    tbl.push_back(mk("spur12", 0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 12,  1,   32'h200));
    tbl.push_back(mk("iss2",   0, 0, 1, 0, 0,  0, 0,  1, 2, 0, 0,   1,   32'h204));
    tbl.push_back(mk("iss3",   0, 0, 1, 0, 0,  0, 0,  1, 3, 0, 0,   1,   32'h20C));
    tbl.push_back(mk("iss4",   0, 0, 1, 0, 0,  0, 0,  1, 4, 0, 0,   1,   32'h21C));
    tbl.push_back(mk("flush",  0, 1, 1, 0, 0,  0, 0,  1, 6, 0, 0,   0,   32'h0));
    tbl.push_back(mk("postfl", 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("iss8",   0, 0, 1, 0, 0,  0, 0,  1, 8, 0, 0,   1,   32'h100));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk("sat8", 0, 0, 1, 8, 1,  0, 0,  0, 0, 0, 0,   0,   32'h100));
    tbl.push_back(mk("setclr", 0, 0, 1, 0, 0,  0, 0,  1, 10, 1, 8,  1,   32'h400));
    tbl.push_back(mk("rstmid", 1, 0, 1, 10, 1, 0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("idle",   0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   1,   32'h0));
    tbl.push_back(mk("iss11",  0, 0, 1, 0, 0,  0, 0,  1, 11, 0, 0,  1,   32'h800));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (tbl[i].name == "sat8" && i + 1 < tbl.size() && tbl[i + 1].name == "setclr")
        chk("sat_value", 32'(stall_count), 32'd15);
    end

    // busy_vec must not react combinationally to wb/flush, and rst dominates flush.
    @(negedge clk);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd13;
    wb_valid = 1'b1; wb_rd = 5'd11; flush = 1'b1;
    #1;
    chk("noflow.busy", busy_vec, 32'h800);
    chk("flush.ready", 32'(issue_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstflush.ready", 32'(issue_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rstflush.busy", busy_vec, 32'h0);
    chk("rstflush.cnt", 32'(stall_count), 32'd0);
    @(negedge clk);
    drive(mk("end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
    @(posedge clk);
    #1;
    chk("end.busy", busy_vec, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
